// File: rtl/picorv_mem_dma_if.sv
// PicoRV32 native memory bus bundle.
// master drives the request, slave answers with ready/rdata.
interface picorv_mem_dma_if;
  logic        mem_valid;
  logic        mem_instr;
  logic        mem_ready;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_rdata;

  modport master (
    output mem_valid, mem_instr, mem_addr,
    output mem_wdata, mem_wstrb,
    input  mem_ready, mem_rdata
  );

  modport slave (
    input  mem_valid, mem_instr, mem_addr,
    input  mem_wdata, mem_wstrb,
    output mem_ready, mem_rdata
  );
endinterface

// File: rtl/picorv_mem_dma.sv
// Word copy / fill DMA master on the PicoRV32 native memory bus.
// Ports: clk/reset, command (start_i..fill_data_i), status
// (busy_o, done_o, err_o, words_done_o), mem bus master modport.
module picorv_mem_dma #(
  parameter int TIMEOUT = 1024,
  parameter int LEN_W   = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_i,
  input  logic             mode_i,
  input  logic [31:0]      src_addr_i,
  input  logic [31:0]      dst_addr_i,
  input  logic [LEN_W-1:0] len_words_i,
  input  logic [31:0]      fill_data_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             err_o,
  output logic [LEN_W-1:0] words_done_o,
  picorv_mem_dma_if.master mem
);

  typedef enum logic [2:0] {
    IDLE, RD, RD_GAP, WR, WR_GAP, FIN
  } state_t;

  localparam int TW = $clog2(TIMEOUT) + 1;

  state_t st_q, st_d;

  logic             valid_q, valid_d;
  logic [31:0]      addr_q, addr_d;
  logic [31:0]      wdata_q, wdata_d;
  logic [3:0]       wstrb_q, wstrb_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic [LEN_W-1:0] wd_q, wd_d;
  logic [TW-1:0]    cnt_q, cnt_d;
  logic [31:0]      data_q, data_d;
  logic [31:0]      src_q, src_d;
  logic [31:0]      dst_q, dst_d;
  logic             mode_q, mode_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [31:0]      fill_q, fill_d;

  logic accept, xfer, stall, tmo, issue;

  assign accept = (st_q == IDLE) && start_i;
  assign xfer   = valid_q && mem.mem_ready;
  assign stall  = valid_q && !mem.mem_ready;
  assign tmo    = stall && (cnt_q == TW'(TIMEOUT - 1));
  // A request is launched while still in a GAP state so
  // mem_valid is low for exactly one cycle between requests.
  assign issue  = (st_d == RD || st_d == WR) &&
                  !valid_q && (st_q != IDLE);

  always_ff @(posedge clk) begin
    if (reset) st_q <= IDLE;
    else       st_q <= st_d;
  end

  always_comb begin
    st_d = st_q;
    unique case (st_q)
      IDLE: if (start_i) begin
        if (len_words_i == '0) st_d = FIN;
        else if (mode_i)       st_d = WR;
        else                   st_d = RD;
      end
      RD: begin
        if (xfer)     st_d = RD_GAP;
        else if (tmo) st_d = FIN;
      end
      RD_GAP: st_d = WR;
      WR: begin
        if (xfer)     st_d = WR_GAP;
        else if (tmo) st_d = FIN;
      end
      WR_GAP: begin
        if (wd_q == len_q) st_d = FIN;
        else if (mode_q)   st_d = WR;
        else               st_d = RD;
      end
      FIN:     st_d = IDLE;
      default: st_d = IDLE;
    endcase
  end

  always_comb begin
    valid_d = valid_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wstrb_d = wstrb_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    err_d   = err_q;
    wd_d    = wd_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    src_d   = src_q;
    dst_d   = dst_q;
    mode_d  = mode_q;
    len_d   = len_q;
    fill_d  = fill_q;

    if (accept) begin
      mode_d = mode_i;
      src_d  = {src_addr_i[31:2], 2'b00};
      dst_d  = {dst_addr_i[31:2], 2'b00};
      len_d  = len_words_i;
      fill_d = fill_data_i;
      err_d  = 1'b0;
      wd_d   = '0;
      busy_d = 1'b1;
    end

    if (issue) begin
      valid_d = 1'b1;
      cnt_d   = '0;
      if (st_d == RD) begin
        addr_d  = src_q;
        wstrb_d = 4'b0000;
      end else begin
        addr_d  = dst_q;
        wstrb_d = 4'b1111;
        wdata_d = mode_q ? fill_q : data_q;
      end
    end

    if (stall) begin
      cnt_d = cnt_q + 1'b1;
      if (tmo) begin
        valid_d = 1'b0;
        err_d   = 1'b1;
      end
    end

    if (xfer) begin
      valid_d = 1'b0;
      if (st_q == RD) begin
        data_d = mem.mem_rdata;
        src_d  = src_q + 32'd4;
      end else begin
        dst_d = dst_q + 32'd4;
        wd_d  = wd_q + 1'b1;
      end
    end

    if (st_q == FIN) begin
      done_d = 1'b1;
      busy_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      wd_q    <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      src_q   <= '0;
      dst_q   <= '0;
      mode_q  <= 1'b0;
      len_q   <= '0;
      fill_q  <= '0;
    end else begin
      valid_q <= valid_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      wd_q    <= wd_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      mode_q  <= mode_d;
      len_q   <= len_d;
      fill_q  <= fill_d;
    end
  end

  assign mem.mem_valid = valid_q;
  assign mem.mem_instr = 1'b0;
  assign mem.mem_addr  = addr_q;
  assign mem.mem_wdata = wdata_q;
  assign mem.mem_wstrb = wstrb_q;
  assign busy_o        = busy_q;
  assign done_o        = done_q;
  assign err_o         = err_q;
  assign words_done_o  = wd_q;

endmodule

// File: doc/picorv_mem_dma.md
Name: picorv_mem_dma

Overview:
- Bus-master (initiator) on the PicoRV32 native memory interface.
- Drives mem_valid/mem_addr/mem_wdata/mem_wstrb and consumes mem_ready/mem_rdata from the word-addressed on-chip memory responder.
- Performs word copy (src -> dst) or word fill (pattern -> dst) on a start command, without CPU involvement.
- Used for memory initialisation and bulk moves, and as a traffic generator for exercising the memory responder.

Parameters:
- TIMEOUT, 1024: max cycles mem_valid may stay high without mem_ready before the transfer aborts with err; must be >= 2.
- LEN_W, 16: width of the length and progress counters.

Ports:
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-high reset
- start  in  1  command strobe, sampled only in IDLE
- mode  in  1  0 = copy, 1 = fill
- src_addr  in  32  copy source byte address; bits [1:0] ignored
- dst_addr  in  32  destination byte address; bits [1:0] ignored
- len_words  in  LEN_W  number of 32-bit words to transfer
- fill_data  in  32  pattern written in fill mode
- busy  out  1  high from the cycle after start is accepted until done
- done  out  1  one-cycle completion pulse (normal or aborted)
- err  out  1  sticky timeout flag; cleared on next accepted start
- words_done  out  LEN_W  count of destination writes accepted this command
- mem_valid  out  1  request valid
- mem_instr  out  1  tied 0
- mem_ready  in  1  responder acknowledge
- mem_addr  out  32  request byte address, bits [1:0] always 0
- mem_wdata  out  32  write data
- mem_wstrb  out  4  0000 = read, 1111 = write
- mem_rdata  in  32  read data, valid when mem_ready = 1

Behaviour:
- Reset:
  - state IDLE.
  - busy, done, err, mem_valid, mem_instr, mem_wstrb, words_done = 0.
  - mem_addr and mem_wdata = 0.
  - Reset asserted mid-transfer abandons the transfer; mem_valid is low on the next cycle and no done pulse is produced.
- All outputs are registered.
- FSM states: IDLE, RD, RD_GAP, WR, WR_GAP, FIN.
- IDLE:
  - start = 1 latches mode, src, dst, len, fill_data, clears err and words_done, and sets busy.
  - len = 0: go to FIN, with no bus activity.
  - Copy: go to RD.
  - Fill: go to WR.
  - Starting a state drives mem_valid high on the following cycle.
- Request handshake:
  - mem_valid, mem_addr, mem_wdata and mem_wstrb stay stable while mem_valid = 1 and mem_ready = 0.
  - The transaction is accepted at the rising edge where mem_valid = 1 and mem_ready = 1.
  - On that edge mem_valid is cleared. It stays low for exactly one cycle (the GAP state) before the next request.
  - mem_ready while mem_valid = 0 is ignored.
- RD:
  - mem_addr = src + 4*i, wstrb = 0000.
  - On accept, capture mem_rdata into the data register and go to RD_GAP, then WR.
- WR:
  - mem_addr = dst + 4*i, wstrb = 1111.
  - mem_wdata = captured data (copy) or fill_data (fill).
  - On accept, words_done and i increment, then go to WR_GAP.
  - After WR_GAP: if i == len go to FIN; otherwise go to RD (copy) or WR (fill).
- FIN:
  - done = 1 for one cycle, busy = 0 in the same cycle, then IDLE.
  - start asserted in the FIN cycle is ignored; start is accepted again from the following cycle.
- Address arithmetic:
  - 32-bit modulo; addresses wrap from 0xFFFFFFFC to 0x00000000.
  - Overlapping src/dst regions are not detected; copy proceeds strictly ascending.
- Timeout:
  - A counter resets on each new mem_valid assertion and increments each cycle with mem_valid = 1 and mem_ready = 0.
  - When the counter reaches TIMEOUT-1 without ready: mem_valid drops next cycle, err is set, and the FSM goes to FIN (done pulses).
  - words_done holds the completed count.
- start while busy is ignored.
- Input changes during busy have no effect.

Test Plan:
- Reset, then idle 10 cycles -> mem_valid, busy, done, err all 0; mem_instr = 0 throughout.
- Fill: mode=1, dst=0x100, len=4, fill=0xA5A5A5A5, single-cycle-ready responder -> exactly 4 writes, to 0x100/0x104/0x108/0x10C, wstrb=1111, no reads; mem_valid low exactly one cycle between requests; words_done=4; single done pulse; memory readback matches.
- Copy: preload 0x000..0x00C with 0x11111111..0x44444444, then copy src=0x0, dst=0x200, len=4 -> alternating read/write order R0,W0,...R3,W3; dst words match source; reads have wstrb=0000.
- len=0 start -> no mem_valid assertion; done pulses two cycles after start; words_done=0.
- Responder stalls mem_ready 5 cycles per request -> address, wdata and wstrb held stable during the stall; results identical to the no-stall run.
- Timeout and recovery:
  - TIMEOUT=16, responder never readies -> mem_valid high 16 cycles then low, err=1, done pulse, words_done=0.
  - Next start clears err.
  - reset asserted mid-copy -> mem_valid low next cycle, no done pulse.
